// File: rtl/cpu_core_if.sv
// Instruction-memory bus: the core drives PC, memory returns INSTRUCTION.
// master = core side, slave = memory side.
interface cpu_core_if;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;

  modport master (
    output PC,
    input  INSTRUCTION
  );

  modport slave (
    input  PC,
    output INSTRUCTION
  );
endinterface

// File: rtl/cpu_core.sv
// Single-cycle 8-bit CPU core with an 8x8 register file.
// Ports: CLK, RESET (sync, active-low), imem (master: PC out, INSTRUCTION in).
module cpu_core #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic       CLK,
  input  logic       RESET,
  cpu_core_if.master imem
);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  logic [31:0] r_pc;
  logic [7:0]  regs [0:7];

  logic [7:0] w_op;
  logic [2:0] w_dest;
  logic [2:0] w_src1;
  logic [2:0] w_src2;
  logic [7:0] w_imm;
  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [7:0] w_res;
  logic       w_we;
  logic       w_unused;

  assign w_op   = imem.INSTRUCTION[31:24];
  assign w_dest = imem.INSTRUCTION[18:16];
  assign w_src1 = imem.INSTRUCTION[10:8];
  assign w_src2 = imem.INSTRUCTION[2:0];
  assign w_imm  = imem.INSTRUCTION[7:0];

  assign w_unused = ^{imem.INSTRUCTION[23:19],
                      imem.INSTRUCTION[15:11]};

  // Asynchronous reads see the pre-write value of DEST.
  assign w_a = regs[w_src1];
  assign w_b = regs[w_src2];

  always_comb begin
    w_we  = 1'b0;
    w_res = 8'h00;
    case (w_op)
      OP_LOADI: begin
        w_we  = 1'b1;
        w_res = w_imm;
      end
      OP_MOV: begin
        w_we  = 1'b1;
        w_res = w_b;
      end
      OP_ADD: begin
        w_we  = 1'b1;
        w_res = w_a + w_b;
      end
      OP_SUB: begin
        w_we  = 1'b1;
        w_res = w_a + (~w_b + 8'd1);
      end
      OP_AND: begin
        w_we  = 1'b1;
        w_res = w_a & w_b;
      end
      OP_OR: begin
        w_we  = 1'b1;
        w_res = w_a | w_b;
      end
      default: begin
        w_we  = 1'b0;
        w_res = 8'h00;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_pc <= RESET_PC;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      r_pc <= r_pc + PC_STEP;
      if (w_we) begin
        regs[w_dest] <= w_res;
      end
    end
  end

  assign imem.PC = r_pc;

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: stimulus queues expected PC/register
// state per edge, a monitor pops and compares after each rising edge.
module tb_cpu_core;

  typedef struct {
    logic [31:0] pc;
    logic        chk;
    logic [2:0]  idx;
    logic [7:0]  val;
    logic        allz;
  } exp_t;

  logic CLK;
  logic RESET;
  cpu_core_if bus ();

  cpu_core #(
    .RESET_PC (32'd0),
    .PC_STEP  (32'd4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .imem  (bus)
  );

  logic [31:0] mem [0:63];
  assign bus.INSTRUCTION = mem[bus.PC[7:2]];

  exp_t exp_q [$];
  int   n_chk;
  int   n_fail;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Monitor
  initial begin
    exp_t e;
    logic [63:0] all;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.PC !== e.pc) begin
          n_fail++;
          $display("FAIL pc: got %h want %h", bus.PC, e.pc);
        end
        if (e.chk) begin
          n_chk++;
          if (dut.regs[e.idx] !== e.val) begin
            n_fail++;
            $display("FAIL r%0d: got %h want %h",
                     e.idx, dut.regs[e.idx], e.val);
          end
        end
        if (e.allz) begin
          all = {dut.regs[0], dut.regs[1], dut.regs[2],
                 dut.regs[3], dut.regs[4], dut.regs[5],
                 dut.regs[6], dut.regs[7]};
          n_chk++;
          if (all !== 64'h0) begin
            n_fail++;
            $display("FAIL regs_clear: got %h want 0", all);
          end
        end
      end
    end
  end

  task automatic step(input logic rst, input logic [31:0] pc,
                      input logic chk, input logic [2:0] idx,
                      input logic [7:0] val, input logic allz);
    exp_t e;
    @(negedge CLK);
    RESET = rst;
    e.pc   = pc;
    e.chk  = chk;
    e.idx  = idx;
    e.val  = val;
    e.allz = allz;
    exp_q.push_back(e);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    RESET  = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hFF000000;
    mem[0]  = 32'h00040005;
    mem[1]  = 32'h00020009;
    mem[2]  = 32'h02060402;
    mem[3]  = 32'h03010402;
    mem[4]  = 32'h000300F0;
    mem[5]  = 32'h0005003C;
    mem[6]  = 32'h04000305;
    mem[7]  = 32'h05070305;
    mem[8]  = 32'h01070005;
    mem[9]  = 32'h07010102;
    mem[10] = 32'h00010003;
    mem[11] = 32'h02010101;
    mem[12] = 32'h000200C8;
    mem[13] = 32'h00030064;
    mem[14] = 32'h02040203;
    mem[15] = 32'h00FD0011;

    step(1'b0, 32'd0, 1'b0, 3'd0, 8'h00, 1'b1);
    step(1'b0, 32'd0, 1'b0, 3'd0, 8'h00, 1'b1);

    step(1'b1, 32'd4,  1'b1, 3'd4, 8'h05, 1'b0);
    step(1'b1, 32'd8,  1'b1, 3'd2, 8'h09, 1'b0);
    step(1'b1, 32'd12, 1'b1, 3'd6, 8'h0E, 1'b0);
    step(1'b1, 32'd16, 1'b1, 3'd1, 8'hFC, 1'b0);
    step(1'b1, 32'd20, 1'b1, 3'd3, 8'hF0, 1'b0);
    step(1'b1, 32'd24, 1'b1, 3'd5, 8'h3C, 1'b0);
    step(1'b1, 32'd28, 1'b1, 3'd0, 8'h30, 1'b0);
    step(1'b1, 32'd32, 1'b1, 3'd7, 8'hFC, 1'b0);
    step(1'b1, 32'd36, 1'b1, 3'd7, 8'h3C, 1'b0);
    step(1'b1, 32'd40, 1'b1, 3'd1, 8'hFC, 1'b0);
    step(1'b1, 32'd44, 1'b1, 3'd1, 8'h03, 1'b0);
    step(1'b1, 32'd48, 1'b1, 3'd1, 8'h06, 1'b0);
    step(1'b1, 32'd52, 1'b1, 3'd2, 8'hC8, 1'b0);
    step(1'b1, 32'd56, 1'b1, 3'd3, 8'h64, 1'b0);
    step(1'b1, 32'd60, 1'b1, 3'd4, 8'h2C, 1'b0);
    step(1'b1, 32'd64, 1'b1, 3'd5, 8'h11, 1'b0);
    step(1'b1, 32'd68, 1'b1, 3'd5, 8'h11, 1'b0);

    step(1'b0, 32'd0, 1'b0, 3'd0, 8'h00, 1'b1);
    step(1'b1, 32'd4, 1'b1, 3'd4, 8'h05, 1'b0);
    step(1'b1, 32'd8, 1'b1, 3'd2, 8'h09, 1'b0);
    step(1'b0, 32'd0, 1'b0, 3'd0, 8'h00, 1'b1);
    step(1'b1, 32'd4,  1'b1, 3'd4, 8'h05, 1'b0);
    step(1'b1, 32'd8,  1'b1, 3'd2, 8'h09, 1'b0);
    step(1'b1, 32'd12, 1'b1, 3'd6, 8'h0E, 1'b0);

    @(posedge CLK);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
